vend_eject_scheduler: RTL and testbench

//  Sits between vendingMachine and the single shared eject actuator (product gate + change tube).

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_cmd_fifo.sv | 54 +++++
 rtl/vend_eject_scheduler.sv | 161 ++++++++++++++++
 tb/tb_vend_eject_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared encodings for the vending eject scheduler: actuator selects, FSM states
// and the queued transaction entry.
package vend_pkg;

    localparam logic [1:0] SEL_PRODUCT = 2'b00;
    localparam logic [1:0] SEL_NICKEL  = 2'b01;
    localparam logic [1:0] SEL_DIME    = 2'b10;

    localparam int DIMES_W = 2;
    localparam int ENTRY_W = 2 + DIMES_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic               prod;
        logic               nick;
        logic [DIMES_W-1:0] dimes;
    } entry_t;

    function automatic logic entry_busy(input entry_t e);
        return e.prod | e.nick | (e.dimes != '0);
    endfunction

endpackage

// File: rtl/vend_cmd_fifo.sv
// Small synchronous transaction queue; a push on full is accepted only when a
// pop frees a slot in the same cycle.
module vend_cmd_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic   [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vend_eject_scheduler.sv
// Serialises product/change pulses from the vending FSM onto one eject actuator
// and tracks coin tube inventory for the coin acceptor lockout.
module vend_eject_scheduler
    import vend_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8,
    parameter int NICKEL_INIT = 20,
    parameter int DIME_INIT   = 20,
    parameter int LOW_MARK    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             disp_in,
    input  logic             ret_nickel_in,
    input  logic             ret_dime_in,
    input  logic             ret_two_dimes_in,
    input  logic             coin_n,
    input  logic             coin_d,
    input  logic             eject_ack,
    output logic             eject_req,
    output logic [1:0]       eject_sel,
    output logic             coin_lockout,
    output logic             low_change,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt,
    output logic             cmd_overflow,
    output logic             change_fault
);

    state_e           state_q, state_d;
    entry_t           work_q, work_d, push_entry, fifo_dout;
    logic [1:0]       sel_q, sel_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] nickel_q, nickel_d, dime_q, dime_d;
    logic             ovf_q, ovf_d, fault_q, fault_d;
    logic             push, pop, fifo_full, fifo_empty, nick_dec, dime_dec;

    assign push       = disp_in | ret_nickel_in | ret_dime_in | ret_two_dimes_in;
    // {two_dimes, dime} is exactly ret_dime_in + 2*ret_two_dimes_in
    assign push_entry = '{prod: disp_in, nick: ret_nickel_in, dimes: {ret_two_dimes_in, ret_dime_in}};
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;

    vend_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        sel_d    = sel_q;
        fault_d  = fault_q;
        nick_dec = 1'b0;
        dime_dec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    work_d  = fifo_dout;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (work_q.prod) begin
                    sel_d   = SEL_PRODUCT;
                    state_d = ST_WAIT;
                end else if (work_q.nick) begin
                    if (nickel_q == '0) begin
                        work_d.nick = 1'b0;
                        fault_d     = 1'b1;
                    end else begin
                        sel_d   = SEL_NICKEL;
                        state_d = ST_WAIT;
                    end
                end else if (work_q.dimes != '0) begin
                    // an empty dime tube abandons every dime still owed
                    if (dime_q == '0) begin
                        work_d.dimes = '0;
                        fault_d      = 1'b1;
                    end else begin
                        sel_d   = SEL_DIME;
                        state_d = ST_WAIT;
                    end
                end
                if (state_d == ST_ISSUE && !entry_busy(work_d)) state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (eject_ack) begin
                    case (sel_q)
                        SEL_PRODUCT: work_d.prod = 1'b0;
                        SEL_NICKEL: begin
                            work_d.nick = 1'b0;
                            nick_dec    = 1'b1;
                        end
                        default: begin
                            work_d.dimes = work_q.dimes - 2'd1;
                            dime_dec     = 1'b1;
                        end
                    endcase
                    state_d = entry_busy(work_d) ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_d = (state_d == ST_WAIT);
    end

    always_comb begin
        nickel_d = nickel_q;
        dime_d   = dime_q;
        if (coin_n && !nick_dec) begin
            if (nickel_q != '1) nickel_d = nickel_q + CNT_W'(1);
        end else if (nick_dec && !coin_n) begin
            if (nickel_q != '0) nickel_d = nickel_q - CNT_W'(1);
        end
        if (coin_d && !dime_dec) begin
            if (dime_q != '1) dime_d = dime_q + CNT_W'(1);
        end else if (dime_dec && !coin_d) begin
            if (dime_q != '0) dime_d = dime_q - CNT_W'(1);
        end
        ovf_d = ovf_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            sel_q    <= SEL_PRODUCT;
            req_q    <= 1'b0;
            nickel_q <= CNT_W'(NICKEL_INIT);
            dime_q   <= CNT_W'(DIME_INIT);
            ovf_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            sel_q    <= sel_d;
            req_q    <= req_d;
            nickel_q <= nickel_d;
            dime_q   <= dime_d;
            ovf_q    <= ovf_d;
            fault_q  <= fault_d;
        end
    end

    assign eject_req    = req_q;
    assign eject_sel    = sel_q;
    assign nickel_cnt   = nickel_q;
    assign dime_cnt     = dime_q;
    assign cmd_overflow = ovf_q;
    assign change_fault = fault_q;
    assign low_change   = (nickel_q < CNT_W'(LOW_MARK)) | (dime_q < CNT_W'(LOW_MARK));
    assign coin_lockout = fifo_full | low_change;

endmodule

// File: tb/tb_vend_eject_scheduler.sv
// Directed bench for vend_eject_scheduler: a transaction table for the normal
// flows plus hand sequences for overflow, empty tube, counter corners and reset.
module tb_vend_eject_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       disp = 0, rn = 0, rd = 0, r2 = 0, cn = 0, cd = 0, ack = 0;
    logic       req, lockout, low, ovf, fault;
    logic [1:0] sel;
    logic [7:0] ncnt, dcnt;

    logic       rn1 = 0, ack1 = 0;
    logic       req1, lockout1, low1, ovf1, fault1;
    logic [1:0] sel1;
    logic [7:0] ncnt1, dcnt1;

    int n_chk = 0;
    int n_err = 0;

    vend_eject_scheduler u_dut (
        .clk(clk), .reset(reset), .disp_in(disp), .ret_nickel_in(rn), .ret_dime_in(rd),
        .ret_two_dimes_in(r2), .coin_n(cn), .coin_d(cd), .eject_ack(ack),
        .eject_req(req), .eject_sel(sel), .coin_lockout(lockout), .low_change(low),
        .nickel_cnt(ncnt), .dime_cnt(dcnt), .cmd_overflow(ovf), .change_fault(fault)
    );

    vend_eject_scheduler #(.NICKEL_INIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .disp_in(1'b0), .ret_nickel_in(rn1), .ret_dime_in(1'b0),
        .ret_two_dimes_in(1'b0), .coin_n(1'b0), .coin_d(1'b0), .eject_ack(ack1),
        .eject_req(req1), .eject_sel(sel1), .coin_lockout(lockout1), .low_change(low1),
        .nickel_cnt(ncnt1), .dime_cnt(dcnt1), .cmd_overflow(ovf1), .change_fault(fault1)
    );

    typedef struct {
        logic [3:0] pulses;   // {disp, ret_nickel, ret_dime, ret_two_dimes}
        int         nreq;
        int         sels[5];
        int         dly;
        int         exp_n;
        int         exp_d;
        string      name;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!req && n < 40) begin
            tick();
            n++;
        end
        chk({name, " req"}, int'(req), 1);
    endtask

    task automatic serve(input string name, input int exp_sel, input int dly);
        wait_req(name);
        chk({name, " sel"}, int'(sel), exp_sel);
        repeat (dly) tick();
        chk({name, " hold req"}, int'(req), 1);
        chk({name, " hold sel"}, int'(sel), exp_sel);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({name, " gap"}, int'(req), 0);
    endtask

    function automatic vec_t mk(input logic [3:0] p, input int nreq, input int s0, input int s1,
                                input int s2, input int s3, input int s4, input int dly,
                                input int en, input int ed, input string name);
        vec_t v;
        v.pulses = p;
        v.nreq   = nreq;
        v.sels[0] = s0; v.sels[1] = s1; v.sels[2] = s2; v.sels[3] = s3; v.sels[4] = s4;
        v.dly    = dly;
        v.exp_n  = en;
        v.exp_d  = ed;
        v.name   = name;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;

        vecs[0] = mk(4'b1000, 1, 0, 0, 0, 0, 0, 3, 20, 20, "t1_disp");
        vecs[1] = mk(4'b1001, 3, 0, 2, 2, 0, 0, 1, 20, 18, "t2_disp_2dimes");
        vecs[2] = mk(4'b0100, 1, 1, 0, 0, 0, 0, 0, 19, 18, "nickel");
        vecs[3] = mk(4'b0010, 1, 2, 0, 0, 0, 0, 2, 19, 17, "dime");
        vecs[4] = mk(4'b0110, 2, 1, 2, 0, 0, 0, 1, 18, 16, "nick_dime");
        vecs[5] = mk(4'b1111, 5, 0, 1, 2, 2, 2, 0, 17, 13, "all_three_dimes");

        tick();
        tick();
        reset = 1'b0;
        chk("rst req", int'(req), 0);
        chk("rst sel", int'(sel), 0);
        chk("rst ncnt", int'(ncnt), 20);
        chk("rst dcnt", int'(dcnt), 20);
        chk("rst ovf", int'(ovf), 0);
        chk("rst fault", int'(fault), 0);
        chk("rst low", int'(low), 0);
        chk("rst lockout", int'(lockout), 0);

        // T4 on the one-nickel instance
        chk("t4 low", int'(low1), 1);
        chk("t4 lockout", int'(lockout1), 1);
        chk("t4 ncnt init", int'(ncnt1), 1);
        rn1 = 1'b1; tick(); rn1 = 1'b0;
        n = 0;
        while (!req1 && n < 20) begin tick(); n++; end
        chk("t4 req", int'(req1), 1);
        chk("t4 sel", int'(sel1), 1);
        ack1 = 1'b1; tick(); ack1 = 1'b0;
        chk("t4 ncnt after", int'(ncnt1), 0);
        chk("t4 no fault yet", int'(fault1), 0);
        rn1 = 1'b1; tick(); rn1 = 1'b0;
        seen = 1'b0;
        repeat (8) begin tick(); seen |= req1; end
        chk("t4 empty no req", int'(seen), 0);
        chk("t4 fault", int'(fault1), 1);
        chk("t4 ncnt stays", int'(ncnt1), 0);

        // transaction table
        for (int i = 0; i < 6; i++) begin
            {disp, rn, rd, r2} = vecs[i].pulses;
            tick();
            {disp, rn, rd, r2} = 4'b0000;
            if (i == 0) begin
                chk("lat e0", int'(req), 0);
                tick();
                chk("lat e1", int'(req), 0);
                tick();
                chk("lat e2", int'(req), 1);
            end
            for (int k = 0; k < vecs[i].nreq; k++)
                serve($sformatf("%s[%0d]", vecs[i].name, k), vecs[i].sels[k], vecs[i].dly);
            repeat (4) tick();
            chk({vecs[i].name, " idle"}, int'(req), 0);
            chk({vecs[i].name, " ncnt"}, int'(ncnt), vecs[i].exp_n);
            chk({vecs[i].name, " dcnt"}, int'(dcnt), vecs[i].exp_d);
        end

        // T3: product held in WAIT, then five more transactions; the fifth is dropped
        disp = 1'b1; tick(); disp = 1'b0;
        wait_req("t3 first");
        rn = 1'b1;   tick(); rn = 1'b0;
        rd = 1'b1;   tick(); rd = 1'b0;
        disp = 1'b1; tick(); disp = 1'b0;
        rn = 1'b1;   tick(); rn = 1'b0;
        chk("t3 lockout full", int'(lockout), 1);
        chk("t3 ovf before", int'(ovf), 0);
        rd = 1'b1;   tick(); rd = 1'b0;
        chk("t3 ovf", int'(ovf), 1);
        serve("t3 a", 0, 1);
        serve("t3 b", 1, 1);
        serve("t3 c", 2, 1);
        serve("t3 d", 0, 1);
        serve("t3 e", 1, 1);
        repeat (5) tick();
        chk("t3 dropped", int'(req), 0);
        chk("t3 lockout clear", int'(lockout), 0);
        chk("t3 ncnt", int'(ncnt), 15);
        chk("t3 dcnt", int'(dcnt), 12);
        chk("t3 ovf sticky", int'(ovf), 1);

        // T5a: coin increments and simultaneous inc/dec
        cd = 1'b1; tick(); cd = 1'b0;
        chk("t5 coin_d inc", int'(dcnt), 13);
        cn = 1'b1; tick(); cn = 1'b0;
        chk("t5 coin_n inc", int'(ncnt), 16);
        rd = 1'b1; tick(); rd = 1'b0;
        wait_req("t5 dime");
        chk("t5 sel", int'(sel), 2);
        ack = 1'b1; cd = 1'b1; tick(); ack = 1'b0; cd = 1'b0;
        chk("t5 inc+dec", int'(dcnt), 13);
        repeat (3) tick();
        chk("t5 idle", int'(req), 0);

        // T6: reset in the middle of a dime handshake with entries queued
        rd = 1'b1;   tick(); rd = 1'b0;
        wait_req("t6 dime");
        disp = 1'b1; tick(); disp = 1'b0;
        rn = 1'b1;   tick(); rn = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6 req", int'(req), 0);
        chk("t6 sel", int'(sel), 0);
        chk("t6 ncnt", int'(ncnt), 20);
        chk("t6 dcnt", int'(dcnt), 20);
        chk("t6 ovf", int'(ovf), 0);
        ack = 1'b1; repeat (3) tick(); ack = 1'b0;
        seen = 1'b0;
        repeat (6) begin tick(); seen |= req; end
        chk("t6 fifo empty", int'(seen), 0);
        chk("t6 ack ignored ncnt", int'(ncnt), 20);
        chk("t6 ack ignored dcnt", int'(dcnt), 20);

        // T5b: nickel counter saturation
        cn = 1'b1;
        repeat (235) tick();
        cn = 1'b0;
        chk("t5 ncnt 255", int'(ncnt), 255);
        cn = 1'b1;
        repeat (5) tick();
        cn = 1'b0;
        chk("t5 ncnt sat", int'(ncnt), 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
